pdh_demod: RTL
==============

// Module: pdh_demod
// PURPOSE
//  Front end feeding pid_core.dat_i. Mixes signed ADC samples with a signed LO reference,
//  integrates and dumps each decimation window, then outputs an s16 error word with a
//  one-cycle valid strobe. Pipelined, single clock domain, same enable semantics as pid_core.
// PARAMETERS
//  ADC_W  14  ADC / LO sample width (signed)
//  OUT_W  16  output error width (signed)
//  DEC_W  14  decimation counter width
//  ACC_W  42  accumulator width; 2*ADC_W+DEC_W, so the accumulator never overflows
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous reset, active-high
//  enable_i     in   1      run; low = synchronous clear of all datapath state
//  adc_valid_i  in   1      adc_i/lo_i valid this cycle
//  adc_i        in   ADC_W  signed ADC sample
//  lo_i         in   ADC_W  signed LO reference sample
//  decimate_i   in   DEC_W  window length in valid samples; 0 treated as 1
//  shift_i      in   5      arithmetic right shift applied to the dumped sum (0..31)
//  offset_i     in   OUT_W  signed offset added after the shift
//  clr_ovf_i    in   1      clears ovf_o
//  dat_o        out  OUT_W  signed error word, held between strobes
//  dat_valid_o  out  1      one-cycle strobe: dat_o updated
//  ovf_o        out  1      sticky: output saturated since last clear
// BEHAVIOUR
//  - Reset: dat_o=0, dat_valid_o=0, ovf_o=0; acc, count, pipeline and config regs cleared.
//    decimate_r=1, shift_r=0.
//  - enable_i low: same clears as reset, except ovf_o holds. Config regs still track inputs.
//  - Config latch: decimate_r and shift_r latch only when a window starts (count==0 and an
//    accepted sample). Changes mid-window take effect at the next window.
//  - Pipeline (sample presented in cycle N):
//    E0 (edge ending N): capture adc, lo, valid.
//    E1 (N+1): prod = adc*lo, 2*ADC_W signed, exact.
//    E2 (N+2): if last, dump_r = acc+prod and acc=0; else acc += prod.
//    E3 (N+3): dat_o = sat(dump_r>>>shift_r + offset_i); dat_valid_o=1 during N+4.
//  - Latency: last sample of a window -> dat_valid_o is 4 cycles.
//  - Only valid samples advance count. Gaps in adc_valid_i stretch the window and never
//    corrupt it. Back-to-back valid samples are accepted every cycle.
//  - last = (count == decimate_r-1). Count wraps to 0 on last.
//  - Shift is arithmetic (floor): -5>>>1 = -3. The offset add is done at ACC_W+1 bits.
//  - Saturation is symmetric to +/-(2^(OUT_W-1)-1), i.e. +/-32767; -32768 is never
//    produced. Any clip sets ovf_o.
//  - ovf_o: set and clr_ovf_i in the same cycle -> set wins.
//  - enable_i falling mid-window discards the partial window; no strobe is issued.
//  - Re-enable starts a fresh window at count=0.
// CONFIGURATION
//  PDH_DEMOD_DC_BLOCK_EN defined:
//  - Adds input port dc_alpha_i[3:0].
//  - DC estimate state: s16 register y. On each valid sample:
//    y += (adc_i - y) >>> dc_alpha_i.
//  - E0 captures sat14(adc_i - y), using y before the update. Latency is unchanged.
//  - y clears on rst or when enable_i is low.
//  Not defined: no dc_alpha_i port; adc_i is mixed directly.
// TESTING
//  - decimate=4, shift=0, offset=0, adc=50, lo=100 every cycle -> dat_o=20000, strobe
//    every 4 cycles, first strobe 4 cycles after the 4th sample.
//  - Same stimulus with shift=2, offset=-100 -> dat_o=4900. With adc=-50, shift=0,
//    offset=0 -> dat_o=-20000.
//  - decimate=0, adc=lo=-8192 -> decimate treated as 1; dat_o=32767 on every sample, ovf_o=1.
//    Pulse clr_ovf_i with adc=0 -> ovf_o=0.
//  - decimate=3, adc_valid_i high every other cycle, adc=10, lo=10 -> dat_o=300; strobe
//    after every 3rd valid sample.
//  - Drop enable_i after 2 of 4 samples, re-enable -> no strobe for the partial window.
//    Next full window gives 20000 (50x100 stimulus).
//  - Assert rst mid-window -> dat_o=0, dat_valid_o=0 immediately. The first post-reset
//    window is correct.

Source files
------------

// File: rtl/pdh_demod.sv
// pdh_demod: PDH error-signal front end. It mixes signed ADC samples with a signed
// LO reference, integrates each decimation window and dumps it once per window.
// The dumped sum is shifted, offset and saturated to a signed error word that is
// qualified by a one-cycle strobe.
// Optional feature macro: PDH_DEMOD_DC_BLOCK_EN adds a first-order DC-blocking
// stage in front of the mixer and the dc_alpha_i port.
// Handshake: adc_valid_i qualifies adc_i/lo_i in the same cycle. There is no
// backpressure, so every valid sample is accepted. dat_valid_o is high for exactly
// one cycle each time dat_o takes a new value. dat_o holds between strobes.
module pdh_demod #(
  parameter int ADC_W = 14,
  parameter int OUT_W = 16,
  parameter int DEC_W = 14,
  parameter int ACC_W = 2*ADC_W+DEC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    adc_valid_i,
  input  logic signed [ADC_W-1:0] adc_i,
  input  logic signed [ADC_W-1:0] lo_i,
  input  logic        [DEC_W-1:0] decimate_i,
  input  logic        [4:0]       shift_i,
  input  logic signed [OUT_W-1:0] offset_i,
  input  logic                    clr_ovf_i,
`ifdef PDH_DEMOD_DC_BLOCK_EN
  input  logic        [3:0]       dc_alpha_i,
`endif
  output logic signed [OUT_W-1:0] dat_o,
  output logic                    dat_valid_o,
  output logic                    ovf_o
);

  localparam int PROD_W = 2*ADC_W;
  localparam logic signed [ACC_W:0] POS_LIM = (ACC_W+1)'(2**(OUT_W-1)-1);
  localparam logic signed [ACC_W:0] NEG_LIM = -POS_LIM;

  // Configuration latched at window start, and the window position counter
  logic        [DEC_W-1:0] decimate_q, dec_sel;
  logic        [4:0]       shift_q, sh_sel;
  logic        [DEC_W-1:0] count_q;
  logic                    accept, last_e0;

  // E0..E3 pipeline registers. The shift amount travels with each window so that
  // a dump is scaled by its own window's setting.
  logic signed [ADC_W-1:0] s0_adc_q, s0_lo_q;
  logic                    s0_vld_q, s0_last_q;
  logic        [4:0]       s0_sh_q, s1_sh_q, s2_sh_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic                    s1_vld_q, s1_last_q;
  logic signed [ACC_W-1:0] acc_q, dump_q;
  logic                    s2_vld_q;
  logic signed [OUT_W-1:0] dat_q;
  logic                    dat_valid_q, ovf_q;

  logic signed [ADC_W-1:0] adc_mix;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W:0]   sum_w;
  logic signed [OUT_W-1:0] sat_val;
  logic                    clip;

`ifdef PDH_DEMOD_DC_BLOCK_EN
  localparam logic signed [16:0] ADC_MAX = 17'(2**(ADC_W-1)-1);
  localparam logic signed [16:0] ADC_MIN = -17'(2**(ADC_W-1));
  logic signed [15:0] dc_y_q;
  logic signed [16:0] dc_diff, dc_step, dc_sum;

  // DC estimate update and saturated residual, using the estimate before update
  always_comb begin
    dc_diff = 17'(adc_i) - 17'(dc_y_q);
    dc_step = dc_diff >>> dc_alpha_i;
    dc_sum  = 17'(dc_y_q) + dc_step;
    if (dc_diff > ADC_MAX)      adc_mix = ADC_MAX[ADC_W-1:0];
    else if (dc_diff < ADC_MIN) adc_mix = ADC_MIN[ADC_W-1:0];
    else                        adc_mix = dc_diff[ADC_W-1:0];
  end

  // DC estimate register advances only on valid samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                dc_y_q <= '0;
    else if (!enable_i)     dc_y_q <= '0;
    else if (adc_valid_i)   dc_y_q <= dc_sum[15:0];
  end
`else
  assign adc_mix = adc_i;
`endif

  // Window bookkeeping: a new window takes the live config inputs, and 0 acts as 1
  always_comb begin
    accept  = enable_i & adc_valid_i;
    dec_sel = (count_q == '0) ? decimate_i : decimate_q;
    if (dec_sel == '0) dec_sel = DEC_W'(1);
    sh_sel  = (count_q == '0) ? shift_i : shift_q;
    last_e0 = (count_q == dec_sel - DEC_W'(1));
  end

  // Config latch and sample counter. While disabled the config follows the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decimate_q <= DEC_W'(1);
      shift_q    <= '0;
      count_q    <= '0;
    end else if (!enable_i) begin
      decimate_q <= decimate_i;
      shift_q    <= shift_i;
      count_q    <= '0;
    end else if (accept) begin
      if (count_q == '0) begin
        decimate_q <= decimate_i;
        shift_q    <= shift_i;
      end
      count_q <= last_e0 ? '0 : count_q + DEC_W'(1);
    end
  end

  // E0 capture and E1 exact product
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !enable_i) begin
      s0_adc_q <= '0; s0_lo_q <= '0; s0_vld_q <= 1'b0; s0_last_q <= 1'b0; s0_sh_q <= '0;
      s1_prod_q <= '0; s1_vld_q <= 1'b0; s1_last_q <= 1'b0; s1_sh_q <= '0;
    end else begin
      s0_adc_q  <= adc_mix;
      s0_lo_q   <= lo_i;
      s0_vld_q  <= adc_valid_i;
      s0_last_q <= adc_valid_i & last_e0;
      s0_sh_q   <= sh_sel;
      s1_prod_q <= s0_adc_q * s0_lo_q;
      s1_vld_q  <= s0_vld_q;
      s1_last_q <= s0_last_q;
      s1_sh_q   <= s0_sh_q;
    end
  end

  // E2 integrate and dump
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !enable_i) begin
      acc_q <= '0; dump_q <= '0; s2_vld_q <= 1'b0; s2_sh_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          dump_q  <= acc_q + ACC_W'(s1_prod_q);
          s2_sh_q <= s1_sh_q;
          acc_q   <= '0;
        end else begin
          acc_q <= acc_q + ACC_W'(s1_prod_q);
        end
      end
    end
  end

  // Floor shift, offset at one extra bit of headroom, symmetric saturation
  always_comb begin
    shifted = dump_q >>> s2_sh_q;
    sum_w   = {shifted[ACC_W-1], shifted} +
              {{(ACC_W+1-OUT_W){offset_i[OUT_W-1]}}, offset_i};
    clip    = 1'b1;
    if (sum_w > POS_LIM)      sat_val = POS_LIM[OUT_W-1:0];
    else if (sum_w < NEG_LIM) sat_val = NEG_LIM[OUT_W-1:0];
    else begin
      sat_val = sum_w[OUT_W-1:0];
      clip    = 1'b0;
    end
  end

  // E3 output register and strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !enable_i) begin
      dat_q <= '0; dat_valid_q <= 1'b0;
    end else begin
      dat_valid_q <= s2_vld_q;
      if (s2_vld_q) dat_q <= sat_val;
    end
  end

  // Sticky overflow: a new clip wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                ovf_q <= 1'b0;
    else if (enable_i && s2_vld_q && clip)  ovf_q <= 1'b1;
    else if (clr_ovf_i)                     ovf_q <= 1'b0;
  end

  assign dat_o       = dat_q;
  assign dat_valid_o = dat_valid_q;
  assign ovf_o       = ovf_q;

endmodule
